ballot_ctrl: RTL
================

BALLOT_CTRL -- requirements
Module: ballot_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 1000: ARMED-state cycles before an unused ballot expires; must be ≥ 2.
REQ-002 Parameter CNT_W, 8: width of the ballot counter; equals the vote-count width.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mode  input  1  0 = voting, 1 = display; shared with the vote counter.
REQ-006 arm  input  1  officer pulse that authorises exactly one ballot.
REQ-007 btn  input  4  raw candidate buttons, bit i = candidate i+1, level-sensitive.
REQ-008 vote_pulse  output  4  one-hot single-cycle strobe; bit i drives voted_candidate(i+1) of the vote counter.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 accepted  output  1  one-cycle pulse, coincident with the vote_pulse strobe.
REQ-011 rejected  output  1  one-cycle pulse on a multi-button press or a mode abort.
REQ-012 timeout  output  1  one-cycle pulse when an armed ballot expires.
REQ-013 ballots_cast  output  CNT_W  count of accepted ballots; wraps to 0 after 2^CNT_W-1.

Function
REQ-014 The FSM has exactly four states: IDLE, ARMED, CAST, RELEASE.
REQ-015 IDLE -> ARMED when arm=1 and mode=0 and btn=0; otherwise stays in IDLE.
REQ-016 ARMED: btn=0 stays in ARMED.
REQ-017 ARMED: exactly one btn bit set latches btn into a one-hot register and moves to CAST.
REQ-018 ARMED: two or more btn bits set pulse rejected and move to RELEASE; no vote is issued.
REQ-019 ARMED, mode=1 (priority over btn): pulse rejected and return to IDLE.
REQ-020 CAST lasts exactly one cycle.
REQ-021 CAST, mode=0: vote_pulse = latched one-hot, accepted=1, ballots_cast increments by 1, then move to RELEASE.
REQ-022 CAST, mode=1: vote_pulse=0, rejected=1, ballots_cast unchanged, then move to RELEASE.
REQ-023 Latency: a valid press sampled in ARMED at edge N asserts vote_pulse during the cycle after edge N+1.
REQ-024 RELEASE -> IDLE on the first edge that samples btn=0; held buttons never generate a second vote.
REQ-025 arm is ignored in every state except IDLE; arm does not queue.
REQ-026 vote_pulse is 0 in every state except CAST, and never has more than one bit set.
REQ-027 ballots_cast is CNT_W-bit modular; 255+1 -> 0 when CNT_W=8.
REQ-028 All outputs are registered.

Reset
REQ-029 rst=1 forces the state to IDLE.
REQ-030 rst=1 clears vote_pulse, accepted, rejected, timeout, ballots_cast, the latched one-hot register, and the timeout counter.
REQ-031 rst=1 in CAST suppresses the vote pulse for that cycle; rst has priority over all other inputs.

Configuration
REQ-032 Macro BALLOT_TIMEOUT_EN.
REQ-033 With BALLOT_TIMEOUT_EN defined:
- the timeout counter clears on entry to ARMED;
- it increments each cycle in ARMED;
- at TIMEOUT_CYCLES-1 with btn=0, the block pulses timeout and returns to IDLE.
REQ-034 Without BALLOT_TIMEOUT_EN: no timeout counter exists, timeout is tied to 0, and ARMED waits indefinitely.

Structure
REQ-035 Shared package vote_pkg holds:
- the state enum (IDLE/ARMED/CAST/RELEASE);
- NUM_CAND=4;
- the default CNT_W.
REQ-036 No sub-module; the one-hot check (exactly one bit of btn) is a package function, onehot4.

Verification
REQ-037 Single vote: rst, arm, btn=0010 for 3 cycles, then btn=0 -> vote_pulse=0010 for exactly 1 cycle, accepted=1, ballots_cast=1, state returns to IDLE.
REQ-038 Double press: arm, btn=0101 -> rejected=1, vote_pulse never nonzero, ballots_cast unchanged, IDLE after btn=0.
REQ-039 Stuck button: arm, btn=1000 held for 50 cycles, arm pulsed again during the hold -> exactly one vote_pulse=1000, ballots_cast +1.
REQ-040 Timeout (BALLOT_TIMEOUT_EN, TIMEOUT_CYCLES=10): arm, no buttons -> timeout pulse 10 cycles after entering ARMED, IDLE, no vote.
REQ-041 Mode abort: arm, mode=1 in ARMED -> rejected=1, IDLE. Separately, mode=1 in the CAST cycle -> vote_pulse=0, ballots_cast unchanged.
REQ-042 Wrap and reset: 256 valid ballots (CNT_W=8) -> ballots_cast=0. Then rst asserted in the CAST cycle -> no vote_pulse, all outputs 0 on the next edge.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared voting types: FSM state encoding, candidate count, default counter width,
// and the exactly-one-button test used by the ballot controller.
package vote_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAST    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam int NUM_CAND  = 4;
   localparam int DEF_CNT_W = 8;

   // True when exactly one candidate button is pressed.
   function automatic logic onehot4(input logic [NUM_CAND-1:0] v);
      return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

endpackage

// File: rtl/ballot_ctrl_if.sv
// Officer/voter-facing bundle of the ballot controller: master drives the panel
// inputs, slave (the controller) drives the vote strobes and status.
interface ballot_ctrl_if
   import vote_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);

   logic                mode;
   logic                arm;
   logic [NUM_CAND-1:0] btn;
   logic [NUM_CAND-1:0] vote_pulse;
   logic                busy;
   logic                accepted;
   logic                rejected;
   logic                timeout;
   logic [CNT_W-1:0]    ballots_cast;

   modport master (
      output mode, arm, btn,
      input  vote_pulse, busy, accepted, rejected, timeout, ballots_cast
   );

   modport slave (
      input  mode, arm, btn,
      output vote_pulse, busy, accepted, rejected, timeout, ballots_cast
   );

endinterface

// File: rtl/ballot_ctrl.sv
// One-ballot-per-arm voting controller with registered strobes and a modular ballot count.
// Optional ARMED-state expiry is enabled by defining BALLOT_TIMEOUT_EN.
module ballot_ctrl
   import vote_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic          clk,
   input  logic          rst,
   ballot_ctrl_if.slave  bus
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("ballot_ctrl: TIMEOUT_CYCLES must be at least 2");
   end

   state_t              state_r, state_n;
   logic [NUM_CAND-1:0] onehot_r, onehot_n;
   logic [NUM_CAND-1:0] vote_r, vote_n;
   logic                accepted_r, accepted_n;
   logic                rejected_r, rejected_n;
   logic                busy_r;
   logic [CNT_W-1:0]    ballots_r, ballots_n;
   logic                no_btn_s;

   assign no_btn_s = ~|bus.btn;

`ifdef BALLOT_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);

   logic [TO_W-1:0] tmo_cnt_r;
   logic            tmo_hit_s;
   logic            timeout_r, timeout_n;

   assign tmo_hit_s = (tmo_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

   // ARMED dwell counter; held at zero outside ARMED so it starts fresh on entry
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_r <= {TO_W{1'b0}};
      end else if (state_r != ARMED) begin
         tmo_cnt_r <= {TO_W{1'b0}};
      end else begin
         tmo_cnt_r <= tmo_cnt_r + TO_W'(1'b1);
      end
   end
`endif

   // Next-state and next-output decode
   always_comb begin
      state_n    = state_r;
      onehot_n   = onehot_r;
      vote_n     = {NUM_CAND{1'b0}};
      accepted_n = 1'b0;
      rejected_n = 1'b0;
      ballots_n  = ballots_r;
`ifdef BALLOT_TIMEOUT_EN
      timeout_n  = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            if (bus.arm && !bus.mode && no_btn_s) begin
               state_n = ARMED;
            end else begin
               state_n = IDLE;
            end
         end
         ARMED: begin
            if (bus.mode) begin
               rejected_n = 1'b1;
               state_n    = IDLE;
            end else if (no_btn_s) begin
`ifdef BALLOT_TIMEOUT_EN
               if (tmo_hit_s) begin
                  timeout_n = 1'b1;
                  state_n   = IDLE;
               end else begin
                  state_n   = ARMED;
               end
`else
               state_n = ARMED;
`endif
            end else if (onehot4(bus.btn)) begin
               onehot_n = bus.btn;
               state_n  = CAST;
            end else begin
               rejected_n = 1'b1;
               state_n    = RELEASE;
            end
         end
         CAST: begin
            // mode is re-sampled here so a late switch to display still voids the vote
            if (!bus.mode) begin
               vote_n     = onehot_r;
               accepted_n = 1'b1;
               ballots_n  = ballots_r + CNT_W'(1'b1);
            end else begin
               rejected_n = 1'b1;
            end
            state_n = RELEASE;
         end
         RELEASE: begin
            if (no_btn_s) begin
               state_n = IDLE;
            end else begin
               state_n = RELEASE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         onehot_r   <= {NUM_CAND{1'b0}};
         vote_r     <= {NUM_CAND{1'b0}};
         accepted_r <= 1'b0;
         rejected_r <= 1'b0;
         busy_r     <= 1'b0;
         ballots_r  <= {CNT_W{1'b0}};
`ifdef BALLOT_TIMEOUT_EN
         timeout_r  <= 1'b0;
`endif
      end else begin
         state_r    <= state_n;
         onehot_r   <= onehot_n;
         vote_r     <= vote_n;
         accepted_r <= accepted_n;
         rejected_r <= rejected_n;
         busy_r     <= (state_n != IDLE);
         ballots_r  <= ballots_n;
`ifdef BALLOT_TIMEOUT_EN
         timeout_r  <= timeout_n;
`endif
      end
   end

   assign bus.vote_pulse   = vote_r;
   assign bus.accepted     = accepted_r;
   assign bus.rejected     = rejected_r;
   assign bus.busy         = busy_r;
   assign bus.ballots_cast = ballots_r;
`ifdef BALLOT_TIMEOUT_EN
   assign bus.timeout      = timeout_r;
`else
   assign bus.timeout      = 1'b0;
`endif

endmodule
